// File: rtl/mem_fetch_if.sv
// Bus bundle between the tape register file, the fill engine, data memory
// and the write-back stage.
interface mem_fetch_if #(
  parameter int NCORES = 4
);
  logic [NCORES*35-1:0] rf_in;
  logic                 mem_rd_req;
  logic [15:0]          mem_addr;
  logic                 mem_rd_valid;
  logic [15:0]          mem_rd_data;
  logic                 wb_en_out;
  logic [15:0]          ptr_out;
  logic [15:0]          val_out;

  modport master (
    input  rf_in, mem_rd_valid, mem_rd_data,
    output mem_rd_req, mem_addr, wb_en_out, ptr_out, val_out
  );

  modport slave (
    output rf_in, mem_rd_valid, mem_rd_data,
    input  mem_rd_req, mem_addr, wb_en_out, ptr_out, val_out
  );
endinterface

// File: rtl/mem_fetch.sv
// Memory-side fill engine: round-robin picks a retrieving register-file entry,
// reads its tag from memory and returns the value as a one-cycle write-back.
module mem_fetch #(
  parameter int NCORES = 4
) (
  input  logic       clk,
  input  logic       rst,
  mem_fetch_if.master bus
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WB
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       win_q, win_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic                req_q, req_d;
  logic [15:0]         addr_q, addr_d;
  logic                wb_q, wb_d;
  logic [15:0]         ptr_q, ptr_d;
  logic [15:0]         val_q, val_d;
  logic [NCORES-1:0]   served_q, served_d;
  logic [15:0]         served_tag_q [NCORES];
  logic [15:0]         served_tag_d [NCORES];

  logic [NCORES-1:0]   ent_valid, ent_retr, cand;
  logic [15:0]         ent_tag [NCORES];
  logic [NCORES*17-1:0] unused_fields;
  logic                found;
  logic [IW-1:0]       pick;
  logic [IW-1:0]       rr_next;

  // Field decode; locked and val are for the write-back stage, not for us.
  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      ent_valid[i]              = bus.rf_in[i*35 + 34];
      ent_retr[i]               = bus.rf_in[i*35 + 33];
      ent_tag[i]                = bus.rf_in[i*35 + 16 +: 16];
      unused_fields[i*17 +: 17] = {bus.rf_in[i*35 + 32], bus.rf_in[i*35 +: 16]};
    end
  end

  assign cand = ent_valid & ent_retr & ~served_q;

  // First candidate at or above rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (!found && cand[(int'(rr_q) + k) % NCORES]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_q) + k) % NCORES);
      end
    end
  end

  assign rr_next = (win_q == IW'(NCORES - 1)) ? '0 : win_q + 1'b1;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wb_d    = 1'b0;
    ptr_d   = ptr_q;
    val_d   = val_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = pick;
          addr_d  = ent_tag[pick];
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rd_valid) begin
          req_d   = 1'b0;
          ptr_d   = addr_q;
          val_d   = bus.mem_rd_data;
          wb_d    = 1'b1;
          rr_d    = rr_next;
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A returning read marks every entry still asking for that tag, so shared
  // tags cost one fetch. A stale or dropped entry forgets its served mark.
  always_comb begin
    for (int j = 0; j < NCORES; j++) begin
      logic set_j, clr_j;
      set_j = (state_q == S_WAIT) && bus.mem_rd_valid &&
              ent_valid[j] && ent_retr[j] && (ent_tag[j] == addr_q);
      clr_j = !ent_valid[j] || !ent_retr[j] ||
              (served_q[j] && (ent_tag[j] != served_tag_q[j]));
      served_d[j]     = clr_j ? 1'b0 : (set_j ? 1'b1 : served_q[j]);
      served_tag_d[j] = set_j ? ent_tag[j] : served_tag_q[j];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      rr_q     <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wb_q     <= 1'b0;
      ptr_q    <= '0;
      val_q    <= '0;
      served_q <= '0;
      // NOTE: served_tag is a handful of flops, not a RAM, so it is reset
      // alongside the rest of the state.
      for (int j = 0; j < NCORES; j++) served_tag_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_q     <= rr_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wb_q     <= wb_d;
      ptr_q    <= ptr_d;
      val_q    <= val_d;
      served_q <= served_d;
      for (int j = 0; j < NCORES; j++) served_tag_q[j] <= served_tag_d[j];
    end
  end

  assign bus.mem_rd_req = req_q;
  assign bus.mem_addr   = addr_q;
  assign bus.wb_en_out  = wb_q;
  assign bus.ptr_out    = ptr_q;
  assign bus.val_out    = val_q;

endmodule

// File: tb/tb_mem_fetch.sv
// Self-checking bench for mem_fetch: directed scenarios plus randomized rounds
// compared against a round-robin/dedupe reference model.
module tb_mem_fetch;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_fetch_if #(.NCORES(N)) bus ();

  mem_fetch #(.NCORES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_core(input int i, input logic v, input logic r, input logic [15:0] tag);
    bus.rf_in[i*35 +: 35] = {v, r, 1'b0, tag, 16'h0000};
  endtask

  task automatic clear_all();
    bus.rf_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Memory responder for one fetch; called at a negedge. Optionally rewrites
  // one core's tag once the request is seen (mid-fetch stimulus).
  task automatic serve(input string name, input logic [15:0] exp_addr,
                       input logic [15:0] data, input int lat,
                       output int req_cycles,
                       input int mid_core = -1, input logic [15:0] mid_tag = 16'h0);
    int waited = 0;
    req_cycles = 0;
    while (bus.mem_rd_req !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.mem_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL %s req_timeout: mem_rd_req=%b required 1", name, bus.mem_rd_req);
      return;
    end
    checks++;
    if (bus.mem_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s addr: got %h required %h", name, bus.mem_addr, exp_addr);
    end
    if (mid_core >= 0) set_core(mid_core, 1'b1, 1'b1, mid_tag);
    for (int c = 0; c < lat; c++) begin
      req_cycles++;
      @(negedge clk);
      checks++;
      if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== exp_addr || bus.wb_en_out !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: req=%b addr=%h wb=%b required req=1 addr=%h wb=0",
                 name, bus.mem_rd_req, bus.mem_addr, bus.wb_en_out, exp_addr);
      end
    end
    req_cycles++;
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = data;
    @(negedge clk);
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 16'($urandom);
    checks++;
    if (bus.wb_en_out !== 1'b1 || bus.ptr_out !== exp_addr || bus.val_out !== data ||
        bus.mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL %s wb: wb=%b ptr=%h val=%h req=%b required wb=1 ptr=%h val=%h req=0",
               name, bus.wb_en_out, bus.ptr_out, bus.val_out, bus.mem_rd_req, exp_addr, data);
    end
    @(negedge clk);
    checks++;
    if (bus.wb_en_out !== 1'b0 || bus.ptr_out !== exp_addr || bus.val_out !== data) begin
      errors++;
      $display("FAIL %s wb_pulse: wb=%b ptr=%h val=%h required wb=0 ptr=%h val=%h",
               name, bus.wb_en_out, bus.ptr_out, bus.val_out, exp_addr, data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_all();
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 16'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_rd_req, bus.mem_addr, bus.wb_en_out, bus.ptr_out, bus.val_out} !== 50'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%h wb=%b ptr=%h val=%h required all 0",
               bus.mem_rd_req, bus.mem_addr, bus.wb_en_out, bus.ptr_out, bus.val_out);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_rd_req !== 1'b0 || bus.wb_en_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: req=%b wb=%b required 0 0", bus.mem_rd_req, bus.wb_en_out);
    end
  endtask

  task automatic test_single();
    int rc;
    set_core(0, 1'b1, 1'b1, 16'h0010);
    @(negedge clk);
    checks++;
    if (bus.mem_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: req=%b required 1 one cycle after candidate", bus.mem_rd_req);
    end
    serve("single", 16'h0010, 16'hBEEF, 1, rc);
    checks++;
    if (rc != 2) begin
      errors++;
      $display("FAIL single_req_cycles: got %0d required 2", rc);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_rd_req !== 1'b0 || bus.wb_en_out !== 1'b0) begin
        errors++;
        $display("FAIL single_no_refetch: req=%b wb=%b required 0 0", bus.mem_rd_req, bus.wb_en_out);
      end
    end
  endtask

  task automatic test_tag_change();
    int rc;
    set_core(0, 1'b1, 1'b1, 16'h0011);
    serve("tag_change", 16'h0011, 16'($urandom), int'($urandom_range(0, 3)), rc);
    clear_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int rc;
    do_reset();
    set_core(0, 1'b1, 1'b1, 16'h0100);
    set_core(1, 1'b1, 1'b1, 16'h0101);
    set_core(3, 1'b1, 1'b1, 16'h0103);
    serve("rr_first", 16'h0100, 16'h1111, 0, rc);
    serve("rr_second", 16'h0101, 16'h2222, 2, rc, 0, 16'h0200);
    serve("rr_third", 16'h0103, 16'h3333, 1, rc);
    serve("rr_fourth", 16'h0200, 16'h4444, 3, rc);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_rd_req !== 1'b0) begin
        errors++;
        $display("FAIL rr_quiet: req=%b required 0", bus.mem_rd_req);
      end
    end
    clear_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_shared_tag();
    int rc;
    int reads = 0;
    set_core(1, 1'b1, 1'b1, 16'h0042);
    set_core(2, 1'b1, 1'b1, 16'h0042);
    serve("shared", 16'h0042, 16'hCAFE, 1, rc);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mem_rd_req === 1'b1 || bus.wb_en_out === 1'b1) reads++;
    end
    checks++;
    if (reads != 0) begin
      errors++;
      $display("FAIL shared_single_read: extra activity cycles=%0d required 0", reads);
    end
    clear_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stray_response();
    logic [15:0] ptr0, val0;
    clear_all();
    repeat (2) @(negedge clk);
    ptr0 = bus.ptr_out;
    val0 = bus.val_out;
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = 16'h1234;
    @(negedge clk);
    bus.mem_rd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.mem_rd_req !== 1'b0 || bus.wb_en_out !== 1'b0 ||
          bus.ptr_out !== ptr0 || bus.val_out !== val0) begin
        errors++;
        $display("FAIL stray: req=%b wb=%b ptr=%h val=%h required 0 0 %h %h",
                 bus.mem_rd_req, bus.wb_en_out, bus.ptr_out, bus.val_out, ptr0, val0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wait();
    int rc;
    int waited = 0;
    int wb_seen = 0;
    set_core(2, 1'b1, 1'b1, 16'h0777);
    while (bus.mem_rd_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.mem_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_setup: req=%b required 1", bus.mem_rd_req);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_all();
    #1;
    checks++;
    if (bus.mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_drop: req=%b required 0 immediately", bus.mem_rd_req);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = 16'hDEAD;
    @(negedge clk);
    bus.mem_rd_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.wb_en_out === 1'b1 || bus.mem_rd_req === 1'b1) wb_seen++;
      @(negedge clk);
    end
    checks++;
    if (wb_seen != 0) begin
      errors++;
      $display("FAIL rst_wait_no_wb: activity cycles=%0d required 0", wb_seen);
    end
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b1, 16'h0500 + 16'(i));
    for (int i = 0; i < N; i++)
      serve("rst_wait_rr", 16'h0500 + 16'(i), 16'($urandom), int'($urandom_range(0, 2)), rc);
    clear_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int rc;
    int rr_m;
    do_reset();
    rr_m = 0;
    for (int round = 0; round < 8; round++) begin
      logic [N-1:0]  mask;
      logic [15:0]   tags [N];
      bit            done [N];
      logic [15:0]   exp_q [$];
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        tags[i] = 16'h3000 + 16'($urandom_range(0, 3));
        done[i] = 1'b0;
        if (mask[i]) set_core(i, 1'b1, 1'b1, tags[i]);
        else         set_core(i, 1'($urandom_range(0, 1)), 1'b0, tags[i]);
      end
      // Reference: round-robin from rr_m; one fetch satisfies every core sharing the tag.
      forever begin
        int w = -1;
        for (int k = 0; k < N; k++) begin
          int idx = (rr_m + k) % N;
          if (w < 0 && mask[idx] && !done[idx]) w = idx;
        end
        if (w < 0) break;
        exp_q.push_back(tags[w]);
        for (int j = 0; j < N; j++)
          if (mask[j] && tags[j] == tags[w]) done[j] = 1'b1;
        rr_m = (w + 1) % N;
      end
      foreach (exp_q[e])
        serve("random", exp_q[e], 16'($urandom), int'($urandom_range(0, 3)), rc);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (bus.mem_rd_req !== 1'b0) begin
          errors++;
          $display("FAIL random_quiet: round %0d req=%b required 0", round, bus.mem_rd_req);
        end
      end
      clear_all();
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    bus.rf_in        = '0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 16'h0;
    test_reset();
    test_single();
    test_tag_change();
    test_round_robin();
    test_shared_tag();
    test_stray_response();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_fetch.md
Name: mem_fetch

Overview:
- Memory-side fill engine for the per-core tape register file.
- Scans the packed register-file bus for entries that are retrieving from memory (valid=1, retr=1) and arbitrates among them round-robin.
- Issues one read at a time to memory, then drives the value back as a single-cycle val/ptr/wb_en write-back pulse into the write-back stage, which unlocks and fills every matching entry.
- Sits between the register file and the data memory, on the producer side of the write-back interface.

Parameters:
- NCORES, 4, number of cores; the register-file bus carries one 35-bit entry per core.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- rf_in  input  NCORES*35  per-core entry i at [i*35 +: 35] = {valid[34], retr[33], locked[32], tag[31:16], val[15:0]}
- mem_rd_req  output  1  read request to memory; held high until the response arrives
- mem_addr  output  16  read address; stable while mem_rd_req=1
- mem_rd_valid  input  1  one-cycle strobe: mem_rd_data is valid
- mem_rd_data  input  16  read data
- wb_en_out  output  1  write-back strobe to the write-back stage; high for exactly one cycle
- ptr_out  output  16  write-back tag
- val_out  output  16  write-back value

Behaviour:
- Reset (async, immediate): state=IDLE, mem_rd_req=0, mem_addr=0, wb_en_out=0, ptr_out=0, val_out=0, rr_ptr=0, served[*]=0, served_tag[*]=0.
- Candidate for core i: valid[i] & retr[i] & ~served[i].
- Arbitration: lowest index at or above rr_ptr, wrapping modulo NCORES.
- State IDLE:
  - No candidate: stay in IDLE.
  - Candidate present: register winner index w and mem_addr=tag[w], set mem_rd_req=1 on the next edge, go to WAIT.
  - mem_rd_valid is ignored in IDLE.
- State WAIT:
  - Hold mem_rd_req and mem_addr.
  - On mem_rd_valid=1: mem_rd_req=0; latch ptr_out=mem_addr, val_out=mem_rd_data; wb_en_out=1 on the next edge; rr_ptr=(w+1) mod NCORES; go to WB.
  - For every core j with valid[j] & retr[j] & tag[j]==mem_addr in that cycle: set served[j]=1, served_tag[j]=tag[j]. This de-duplicates shared tags.
- State WB: wb_en_out high for this one cycle; wb_en_out=0 on the next edge; go to IDLE.
- ptr_out and val_out hold their last values after the pulse.
- Latency:
  - Candidate visible in cycle N gives mem_rd_req=1 in cycle N+1.
  - mem_rd_valid in cycle M gives wb_en_out=1 in cycle M+1.
  - Minimum 3 cycles per fetch (zero-latency memory responds in the first WAIT cycle).
- served[i] is cleared on any edge where retr[i]=0, valid[i]=0, or tag[i]!=served_tag[i]. Clear takes priority over set for the same core in the same cycle.
- Requesting core drops retr or changes tag during WAIT: the fetch still completes and writes back (the write-back stage ignores tags that no longer match); only still-matching cores are marked served.
- Only one outstanding read. A new candidate arriving during WAIT or WB waits for IDLE.
- Reset during WAIT: the request is dropped immediately; a later mem_rd_valid is ignored; no write-back is produced.
- mem_rd_valid with no request outstanding: ignored.

Test Plan:
- Single request: core0 = {valid=1, retr=1, tag=0x0010}, memory returns 0xBEEF after 2 cycles → mem_rd_req high 2 cycles with mem_addr=0x0010; then exactly one cycle of wb_en_out=1, ptr_out=0x0010, val_out=0xBEEF; no refetch while core0 retr stays 1 with tag 0x0010.
- Round-robin: cores 0, 1 and 3 request tags 0x0100, 0x0101 and 0x0103 → fetch order 0x0100, 0x0101, 0x0103. A fresh core0 request for 0x0200 raised during the 0x0101 fetch is served after 0x0103.
- Shared tag: cores 1 and 2 both request 0x0042 → exactly one memory read and one wb_en_out pulse; served set for both cores.
- Tag change: core0 served for 0x0010 then switches to tag 0x0011 with retr=1 → new fetch issued with mem_addr=0x0011.
- Reset mid-WAIT: assert rst while mem_rd_req=1, then deliver mem_rd_valid after release → mem_rd_req=0 immediately, no wb_en_out pulse, rr_ptr=0.
- Stray response: mem_rd_valid=1 in IDLE with no candidates → all outputs unchanged.
